// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Double-buffered value, per-digit guard interval, optional leading-zero blanking.
module hex_display_scanner #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic                  i_load,
    input  logic                  i_blank_lz,
    output logic [3:0]            o_hex,
    output logic                  o_en,
    output logic [DIGITS-1:0]     o_digit_sel,
    output logic                  o_frame,
    output logic                  o_pending
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        S_GUARD,
        S_ON
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic                pending_q, pending_d;
    logic                blank_lz_q;

    logic                cnt_last;
    logic                idx_last;
    logic                frame;
    logic [DIGITS-1:0]   lz_mask;

    assign cnt_last = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign idx_last = (idx_q == IDX_W'(DIGITS - 1));
    assign frame    = cnt_last && idx_last;

    // Slot counter and digit index
    always_comb begin
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_last) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
    end

    // A load coinciding with the frame boundary bypasses the shadow so it is
    // visible in the very next frame rather than one frame later.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (frame) begin
            if (i_load) begin
                active_d  = i_value;
                shadow_d  = i_value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (i_load) begin
            shadow_d  = i_value;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_GUARD;
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            pending_q  <= 1'b0;
            blank_lz_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            blank_lz_q <= i_blank_lz;
            case (state_q)
                S_GUARD: if (cnt_q == CNT_W'(GUARD - 1)) state_q <= S_ON;
                S_ON:    if (cnt_last) state_q <= S_GUARD;
                default: state_q <= S_GUARD;
            endcase
        end
    end

    // Digit k (k >= 1) is a leading zero when nibbles k..DIGITS-1 are all zero
    always_comb begin
        int unsigned k;
        logic        all_zero;
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            k          = DIGITS - 1 - j;
            all_zero   = all_zero & (active_q[4*k +: 4] == 4'h0);
            lz_mask[k] = all_zero & (k != 0);
        end
    end

    always_comb begin
        o_digit_sel = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (state_q == S_ON && idx_q == IDX_W'(i)) begin
                o_digit_sel[i] = 1'b0;
            end
        end
    end

    assign o_hex     = active_q[{idx_q, 2'b00} +: 4];
    assign o_en      = (state_q == S_ON) && !(blank_lz_q && lz_mask[idx_q]);
    assign o_frame   = frame;
    assign o_pending = pending_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner: directed scenarios plus random
// loads/blanking, checked against a cycle-number based reference model.
module tb_hex_display_scanner;

    localparam int D   = 4;
    localparam int DIV = 8;
    localparam int G   = 2;
    localparam int FRM = D * DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value;
    logic          load;
    logic          blank;
    logic [3:0]    hex;
    logic          en;
    logic [D-1:0]  sel;
    logic          frame;
    logic          pending;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          t;
    logic [15:0] m_active, m_shadow;
    logic        m_pending;
    logic        m_blank_prev;

    hex_display_scanner #(
        .DIGITS  (D),
        .CLK_DIV (DIV),
        .GUARD   (G)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_value     (value),
        .i_load      (load),
        .i_blank_lz  (blank),
        .o_hex       (hex),
        .o_en        (en),
        .o_digit_sel (sel),
        .o_frame     (frame),
        .o_pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s (cycle %0d): got %h expected %h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [15:0] nib(input logic [15:0] v, input int k);
        return (v >> (4 * k)) & 16'hF;
    endfunction

    task automatic check_outputs();
        int          slot, off;
        logic [3:0]  e_sel;
        logic        e_en;
        slot  = (t / DIV) % D;
        off   = t % DIV;
        e_sel = (off < G) ? 4'hF : ~(4'b0001 << slot);
        e_en  = (off >= G) && !(m_blank_prev && slot >= 1 && (m_active >> (4 * slot)) == 16'h0);
        check("digit_sel", {12'h0, sel},     {12'h0, e_sel});
        check("hex",       {12'h0, hex},     nib(m_active, slot));
        check("en",        {15'h0, en},      {15'h0, e_en});
        check("frame",     {15'h0, frame},   {15'h0, (t % FRM) == FRM - 1});
        check("pending",   {15'h0, pending}, {15'h0, m_pending});
    endtask

    // One clock cycle: drive, check, advance model at the edge
    task automatic cyc(input logic ld, input logic [15:0] v);
        load  = ld;
        value = v;
        #1;
        check_outputs();
        @(posedge clk);
        if ((t % FRM) == FRM - 1) begin
            if (ld) begin
                m_active  = v;
                m_shadow  = v;
                m_pending = 1'b0;
            end else if (m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
        end else if (ld) begin
            m_shadow  = v;
            m_pending = 1'b1;
        end
        m_blank_prev = blank;
        t++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_sel",     {12'h0, sel},     16'h000F);
        check("rst_en",      {15'h0, en},      16'h0000);
        check("rst_hex",     {12'h0, hex},     16'h0000);
        check("rst_frame",   {15'h0, frame},   16'h0000);
        check("rst_pending", {15'h0, pending}, 16'h0000);
        rst          = 1'b0;
        t            = 0;
        m_active     = '0;
        m_shadow     = '0;
        m_pending    = 1'b0;
        m_blank_prev = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        blank = 1'b0;
        t     = 0;
        @(negedge clk);

        // 1. Reset and idle scan
        do_reset();
        idle(64);

        // 2. Load and commit
        do_reset();
        idle(5);
        cyc(1'b1, 16'h1A2F);
        idle(58);

        // 3. Last load wins
        do_reset();
        idle(3);
        cyc(1'b1, 16'h1111);
        idle(16);
        cyc(1'b1, 16'h2222);
        idle(44);

        // 4. Load on a frame boundary with an older value pending
        do_reset();
        idle(10);
        cyc(1'b1, 16'h0001);
        idle(20);
        cyc(1'b1, 16'hBEEF);
        idle(32);

        // 5. Leading-zero blanking
        do_reset();
        blank = 1'b1;
        cyc(1'b1, 16'h0050);
        idle(62);
        cyc(1'b1, 16'h0000);
        idle(63);
        blank = 1'b0;

        // 6. Reset mid-slot with a pending value
        do_reset();
        idle(4);
        cyc(1'b1, 16'h9876);
        idle(8);
        do_reset();
        idle(40);

        // Random loads, blanking toggles and occasional resets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic        ld;
            logic [15:0] v;
            v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            if ($urandom_range(0, 7) == 0) v = v & 16'h000F;
            ld = ($urandom_range(0, 24) == 0) ||
                 (((t % FRM) == FRM - 1) && $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 60) == 0) blank = ~blank;
            if ($urandom_range(0, 400) == 0) do_reset();
            else cyc(ld, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a packed hex value, walks the digits one at a time and drives the per-digit `seven_segment` decoder through a 4-bit nibble and an enable. It also drives the active-low digit anodes, with a guard interval between digits to suppress ghosting. New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- `DIGITS`, 4: number of digits; legal 1..8.
- `CLK_DIV`, 50000: clock cycles per digit slot; must be ≥ `GUARD`+2.
- `GUARD`, 16: cycles at the start of each slot with all anodes off; must be ≥ 1.

- `i_clk`  in  1  clock; the block has one clock.
- `i_rst`  in  1  reset; synchronous and active-high.
- `i_value`  in  4*DIGITS  packed hex value; nibble k belongs to digit k, and digit 0 is least significant (rightmost).
- `i_load`  in  1  one-cycle strobe that captures `i_value` into the shadow register.
- `i_blank_lz`  in  1  enables leading-zero blanking; sampled every cycle.
- `o_hex`  out  4  nibble for the current digit; connects to the decoder `i_hex`.
- `o_en`  out  1  decoder enable; 0 blanks the segments.
- `o_digit_sel`  out  DIGITS  active-low anode drive; at most one bit is low at any time.
- `o_frame`  out  1  one-cycle pulse marking the last cycle of each frame.
- `o_pending`  out  1  a loaded value is waiting for commit.

## Operation
- **Registers**
  - `cnt` counts 0..CLK_DIV-1 and wraps.
  - `idx` counts 0..DIGITS-1 and increments when `cnt` wraps; it wraps after DIGITS-1.
  - `state` is GUARD or ON.
  - `shadow` and `active` are each 4*DIGITS bits.
  - `pending` is 1 bit.
- **FSM**
  - GUARD lasts while `cnt` < `GUARD`. It goes to ON when `cnt` = `GUARD`-1.
  - ON lasts while `cnt` ≥ `GUARD`. It goes to GUARD when `cnt` = CLK_DIV-1; `idx` advances on that same edge.
- **Outputs** are decoded from registers only, with no combinational path from inputs to outputs.
  - `o_digit_sel` is all ones in GUARD. In ON, only bit `idx` is 0.
  - `o_hex` is `active[4*idx +: 4]` in both states.
  - `o_en` is 0 in GUARD. In ON it is 1 unless the digit is blanked.
  - `o_frame` is 1 when `idx` = DIGITS-1 and `cnt` = CLK_DIV-1.
  - `o_pending` equals `pending`.
- **Leading-zero blanking**
  - Applies only when `i_blank_lz` = 1.
  - Digit k ≥ 1 is blanked if nibbles k..DIGITS-1 of `active` are all zero.
  - Digit 0 is never blanked.
- **Loading and commit**
  - On `i_load` without a frame boundary: `shadow` ← `i_value` and `pending` ← 1. A later load overwrites the shadow (last load wins).
  - At a frame boundary (`o_frame` = 1) with `pending` = 1 and no `i_load`: `active` ← `shadow` and `pending` ← 0.
  - At a frame boundary with `i_load` = 1: `active` ← `i_value` directly, `shadow` ← `i_value`, `pending` ← 0.
  - At a frame boundary with `pending` = 0 and no load: `active` is unchanged.
- **DIGITS = 1**: `idx` stays 0 and every slot ends a frame.

## Timing
- **Reset** (i_rst high at an edge) sets every register to its reset value:
  - `cnt` = 0, `idx` = 0, `state` = GUARD.
  - `shadow` = 0, `active` = 0, `pending` = 0.
- **Outputs during and after reset**: `o_digit_sel` all ones, `o_en` = 0, `o_hex` = 0, `o_frame` = 0, `o_pending` = 0.
- **Reset mid-operation** aborts the slot immediately and discards any pending value.
- **Cycle numbering**: cycle 0 is the first cycle with `i_rst` low.
  - Anode 0 is low during cycles `GUARD`..CLK_DIV-1.
  - Digit k is lit during cycles k·CLK_DIV+`GUARD` .. (k+1)·CLK_DIV-1.
  - `o_frame` is high in cycle DIGITS·CLK_DIV-1.
- **Load latency**
  - `o_pending` rises one cycle after the `i_load` edge.
  - The committed value appears on `o_hex` in the cycle after `o_frame`, as the digit 0 slot begins.
- **Anode switching**: the anodes are all high for exactly `GUARD` cycles between consecutive digits, including across the frame wrap.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=8, GUARD=2.

1. **Reset and idle scan.** Hold reset, release it, run 64 cycles with no load. Required:
   - `o_digit_sel` = 1111 in cycles 0–1, 1110 in cycles 2–7, 1111 in cycles 8–9, 1101 in cycles 10–15, and so on.
   - `o_hex` = 0 throughout.
   - `o_frame` pulses in cycles 31 and 63.
2. **Load and commit.** Pulse `i_load` in cycle 5 with `i_value` = 16'h1A2F. Required:
   - `o_pending` = 1 from cycle 6.
   - Digits keep showing 0 until the `o_frame` pulse in cycle 31.
   - From cycle 32, `o_pending` = 0 and slots 0–3 show F, 2, A, 1.
3. **Last load wins.** Load 16'h1111 in cycle 3, then 16'h2222 in cycle 20. Required: the display shows 2 on all digits from cycle 32.
4. **Load on a boundary.** Pulse `i_load` with 16'hBEEF in cycle 31 while a pending 16'h0001 exists. Required: 16'hBEEF is shown from cycle 32 and `o_pending` = 0 in cycle 32.
5. **Leading-zero blanking.** Set `active` = 16'h0050 and `i_blank_lz` = 1. Required:
   - `o_en` = 0 in the digit 3 and digit 2 ON windows.
   - `o_en` = 1 in the digit 1 and digit 0 windows.
   - With 16'h0000, only digit 0 is enabled and shows 0.
6. **Reset mid-slot.** Assert `i_rst` in cycle 13 while digit 1 is lit and a load is pending. Required: the cycle after the reset edge shows `o_digit_sel` = 1111, `o_pending` = 0, and the scan restarts at digit 0.
